// File: rtl/mem_tg_pkg.sv
// Shared types for the memory traffic generator.
// FSM state and run-mode encodings.
package mem_tg_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_READ_REQ  = 3'd2,
    S_READ_WAIT = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_FILL       = 2'b00,
    MODE_CHECK      = 2'b01,
    MODE_FILL_CHECK = 2'b10,
    MODE_RSVD       = 2'b11
  } mode_e;

endpackage

// File: rtl/mem_traffic_gen.sv
// Memory fill/check traffic generator with pattern seed + address.
// Define MEM_TG_TIMEOUT_EN to bound the read-response wait.
module mem_traffic_gen
  import mem_tg_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH      = 64,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int ADDR_WIDTH    = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  req_valid,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  valid_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE =
    ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0] E_ONE =
    (ADDR_WIDTH + 1)'(1);

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     err_q, err_d;
  logic [ADDR_WIDTH-1:0]   first_q, first_d;
  logic                    pass_q, pass_d;
  logic [DATA_WIDTH-1:0]   pat;
  logic                    to_hit;
  logic                    resp;
  logic                    miss;

  assign pat = seed_q + DATA_WIDTH'(addr_q);

`ifdef MEM_TG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;

  always_comb begin
    to_hit = (state_q == S_READ_WAIT) && !valid_data &&
             (to_q == TW'(TIMEOUT_CYCLES - 1));
    to_d   = '0;
    if (state_q == S_READ_WAIT && !valid_data && !to_hit)
      to_d = to_q + TW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) to_q <= '0;
    else          to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  // A timed-out read is scored as a miscompare.
  assign resp = (state_q == S_READ_WAIT) &&
                (valid_data || to_hit);
  assign miss = valid_data ? (rdata != pat) : 1'b1;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    seed_d  = seed_q;
    addr_d  = addr_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          seed_d  = seed;
          addr_d  = '0;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          unique case (mode_e'(mode))
            MODE_FILL,
            MODE_FILL_CHECK: state_d = S_WRITE;
            MODE_CHECK:      state_d = S_READ_REQ;
            default:         state_d = S_DONE;
          endcase
        end
      end
      S_WRITE: begin
        if (addr_q == LAST) begin
          addr_d  = '0;
          state_d = (mode_q == MODE_FILL_CHECK) ?
                    S_READ_REQ : S_DONE;
        end else begin
          addr_d = addr_q + A_ONE;
        end
      end
      S_READ_REQ: state_d = S_READ_WAIT;
      S_READ_WAIT: begin
        if (resp) begin
          if (miss) begin
            err_d = err_q + E_ONE;
            if (err_q == '0) first_d = addr_q;
          end
          if (addr_q == LAST) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + A_ONE;
            state_d = S_READ_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Result settles on DONE entry so it is valid alongside done.
    if (state_d == S_DONE && state_q != S_DONE)
      pass_d = (err_d == '0) && (mode_d != MODE_RSVD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_FILL;
      seed_q  <= '0;
      addr_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  assign req_valid = (state_q == S_WRITE) ||
                     (state_q == S_READ_REQ);
  assign we        = (state_q == S_WRITE);
  assign addr      = addr_q;
  assign wdata     = (state_q == S_WRITE) ? pat : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign first_err_addr = first_q;

endmodule
